// File: rtl/stopwatch_pkg.sv
// Shared state encoding and widths for the stopwatch sequencing controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} sw_state_t;

    localparam int BCD_W = 8;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divides the system clock to a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while neither enable nor zero is asserted.
module tick_prescaler #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clock,
    input  logic rst,
    input  logic enable,
    input  logic zero,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (zero) begin
                count <= '0;
            end else if (enable) begin
                // The wrap edge raises tick, so it is visible the cycle after.
                if (count == LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: button pulses -> counter tick/clear, lap hold, display mux.
// Optional lap feature is compiled in with macro STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear_btn,
    input  logic [BCD_W-1:0] number,
    output logic             second_tick,
    output logic             counter_clear,
    output logic [BCD_W-1:0] display_number,
    output logic             running,
    output logic             lap_active
);

    sw_state_t state;
    sw_state_t next_state;
    logic      presc_enable;
    logic      presc_zero;

`ifdef STOPWATCH_LAP_EN
    logic [BCD_W-1:0] lap_reg;
    logic             capture;
`endif

    // Prescaler follows the current state, not the pending transition.
    assign presc_enable = (state == RUNNING) || (state == LAP);
    assign presc_zero   = (state == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .rst    (rst),
        .enable (presc_enable),
        .zero   (presc_zero),
        .tick   (second_tick)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Priority clear_btn > start_stop > lap; a dominated pulse is dropped.
    always_comb begin
        next_state = state;
`ifdef STOPWATCH_LAP_EN
        capture    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (clear_btn) begin
                    next_state = IDLE;
                end else if (start_stop) begin
                    next_state = RUNNING;
                end
            end
            RUNNING: begin
                if (clear_btn) begin
                    next_state = IDLE;
                end else if (start_stop) begin
                    next_state = PAUSED;
                end else if (lap) begin
`ifdef STOPWATCH_LAP_EN
                    next_state = LAP;
                    capture    = 1'b1;
`else
                    next_state = RUNNING;
`endif
                end
            end
            PAUSED: begin
                if (clear_btn) begin
                    next_state = IDLE;
                end else if (start_stop) begin
                    next_state = RUNNING;
                end
            end
`ifdef STOPWATCH_LAP_EN
            LAP: begin
                if (clear_btn) begin
                    next_state = IDLE;
                end else if (start_stop) begin
                    next_state = PAUSED;
                end else if (lap) begin
                    next_state = RUNNING;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state.
    always_ff @(posedge clock) begin
        if (rst) begin
            counter_clear  <= 1'b1;
            running        <= 1'b0;
            display_number <= '0;
        end else begin
            counter_clear <= (next_state == IDLE);
            running       <= (next_state == RUNNING) || (next_state == LAP);
`ifdef STOPWATCH_LAP_EN
            display_number <= (state == LAP) ? lap_reg : number;
`else
            display_number <= number;
`endif
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clock) begin
        if (rst) begin
            lap_reg    <= '0;
            lap_active <= 1'b0;
        end else begin
            lap_active <= (next_state == LAP);
            if (next_state == IDLE) begin
                lap_reg <= '0;
            end else if (capture) begin
                lap_reg <= number;
            end
        end
    end
`else
    assign lap_active = 1'b0;
`endif

endmodule
